// File: rtl/arm_pkg.sv
// Shared ARM pipeline constants: register-file address width, GPR count and
// the PC address, which is never tracked by the hazard scoreboard.
package arm_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int NUM_GPR    = 15;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t PC_ADDR = 4'd15;

endpackage

// File: rtl/sb_counter.sv
// Per-register in-flight write counter: one increment, two decrements per edge,
// clamped to [0, max_i]; underflow_o flags a decrement request larger than the count.
module sb_counter #(
  parameter int CW = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inc_i,
  input  logic          decA_i,
  input  logic          decB_i,
  input  logic [CW-1:0] max_i,
  output logic [CW-1:0] cnt_o,
  output logic          underflow_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   total, decSum, net;

  // One extra bit so the sum of events never wraps before the clamp is applied.
  always_comb begin
    total       = {1'b0, cnt_q} + {{CW{1'b0}}, inc_i};
    decSum      = {{CW{1'b0}}, decA_i} + {{CW{1'b0}}, decB_i};
    net         = total - decSum;
    underflow_o = decSum > {1'b0, cnt_q};
    cnt_d       = net[CW-1:0];
    if (decSum > total) begin
      cnt_d = '0;
    end else if (net > {1'b0, max_i}) begin
      cnt_d = max_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard driving the decode stall. Optional stall-cycle
// performance counter is compiled in with HAZARD_SB_STALL_CNT_EN.
module hazard_scoreboard
  import arm_pkg::*;
#(
  parameter int ADDRESS_LEN_REG_FILE = REG_ADDR_W,
  parameter int SIZE_REG_FILE        = NUM_GPR,
  parameter int MAX_INFLIGHT         = 3
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] src1_i,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] src2_i,
  input  logic                            two_src_i,
  input  logic                            issue_valid_i,
  input  logic                            issue_wb_en_i,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] issue_dest_i,
  input  logic                            kill_valid_i,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] kill_dest_i,
  input  logic                            wb_wb_en_i,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] wb_dest_i,
  output logic                            hazard_o,
  output logic                            sb_err_o,
  output logic [31:0]                     stall_cycles_o
);

  localparam int            CW      = $clog2(MAX_INFLIGHT + 1);
  localparam int            NADDR   = 1 << ADDRESS_LEN_REG_FILE;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

  logic [SIZE_REG_FILE-1:0] incVec, decWbVec, decKillVec, underflowVec;
  logic [SIZE_REG_FILE-1:0] busyReg, fullReg;
  logic [NADDR-1:0]         busyVec, fullVec;
  logic                     incEff;
  logic                     sbErr_q, sbErr_d;

  // Untracked addresses (PC and anything past the GPRs) read as idle and not full.
  always_comb begin
    busyVec                     = '0;
    fullVec                     = '0;
    busyVec[SIZE_REG_FILE-1:0]  = busyReg;
    fullVec[SIZE_REG_FILE-1:0]  = fullReg;
  end

  assign hazard_o = busyVec[src1_i]
                  | (two_src_i & busyVec[src2_i])
                  | (issue_wb_en_i & fullVec[issue_dest_i]);

  assign incEff = issue_valid_i & issue_wb_en_i & ~hazard_o;

  for (genvar r = 0; r < SIZE_REG_FILE; r++) begin : gReg
    localparam logic [ADDRESS_LEN_REG_FILE-1:0] ADDR = ADDRESS_LEN_REG_FILE'(r);
    logic [CW-1:0] cnt;

    assign incVec[r]     = incEff & (issue_dest_i == ADDR);
    assign decWbVec[r]   = wb_wb_en_i & (wb_dest_i == ADDR);
    assign decKillVec[r] = kill_valid_i & (kill_dest_i == ADDR);

    sb_counter #(
      .CW(CW)
    ) uCnt (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .inc_i       (incVec[r]),
      .decA_i      (decWbVec[r]),
      .decB_i      (decKillVec[r]),
      .max_i       (MAX_CNT),
      .cnt_o       (cnt),
      .underflow_o (underflowVec[r])
    );

    assign busyReg[r] = (cnt != '0);
    assign fullReg[r] = (cnt == MAX_CNT);
  end

  assign sbErr_d = sbErr_q | (|underflowVec);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sbErr_q <= 1'b0;
    end else begin
      sbErr_q <= sbErr_d;
    end
  end

  assign sb_err_o = sbErr_q;

`ifdef HAZARD_SB_STALL_CNT_EN
  logic [31:0] stallCycles_q, stallCycles_d;

  assign stallCycles_d = stallCycles_q + {31'd0, hazard_o};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stallCycles_q <= '0;
    end else begin
      stallCycles_q <= stallCycles_d;
    end
  end

  assign stall_cycles_o = stallCycles_q;
`else
  assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard plus hand sequences for
// asynchronous reset and the stall-cycle counter.
module tb_hazard_scoreboard;
  import arm_pkg::*;

  typedef struct {
    string     name;
    reg_addr_t src1;
    reg_addr_t src2;
    logic      twoSrc;
    logic      issValid;
    logic      issWbEn;
    reg_addr_t issDest;
    logic      killValid;
    reg_addr_t killDest;
    logic      wbEn;
    reg_addr_t wbDest;
    logic      expHazard;
    logic      expSbErr;
  } vec_t;

  logic        clock = 1'b0;
  logic        rstN  = 1'b0;
  reg_addr_t   src1 = '0, src2 = '0, issDest = '0, killDest = '0, wbDest = '0;
  logic        twoSrc = 1'b0, issValid = 1'b0, issWbEn = 1'b0;
  logic        killValid = 1'b0, wbEn = 1'b0;
  logic        hazard, sbErr;
  logic [31:0] stallCycles;

  int          checks = 0;
  int          passed = 0;
  int          expStall = 0;
  vec_t        vecs[$];

  hazard_scoreboard dut (
    .clk_i          (clock),
    .rst_ni         (rstN),
    .src1_i         (src1),
    .src2_i         (src2),
    .two_src_i      (twoSrc),
    .issue_valid_i  (issValid),
    .issue_wb_en_i  (issWbEn),
    .issue_dest_i   (issDest),
    .kill_valid_i   (killValid),
    .kill_dest_i    (killDest),
    .wb_wb_en_i     (wbEn),
    .wb_dest_i      (wbDest),
    .hazard_o       (hazard),
    .sb_err_o       (sbErr),
    .stall_cycles_o (stallCycles)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(string n, int s1, int s2, bit ts, bit iv, bit iw, int id,
                              bit kv, int kd, bit we, int wd, bit eh, bit ee);
    vec_t v;
    v.name = n;        v.src1 = 4'(s1);     v.src2 = 4'(s2);     v.twoSrc = ts;
    v.issValid = iv;   v.issWbEn = iw;      v.issDest = 4'(id);
    v.killValid = kv;  v.killDest = 4'(kd); v.wbEn = we;         v.wbDest = 4'(wd);
    v.expHazard = eh;  v.expSbErr = ee;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  // Each vector owns exactly one rising edge: drive on the falling edge, check
  // the pre-edge outputs 1ns later, and let the following posedge apply events.
  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    src1 = v.src1;          src2 = v.src2;          twoSrc = v.twoSrc;
    issValid = v.issValid;  issWbEn = v.issWbEn;    issDest = v.issDest;
    killValid = v.killValid; killDest = v.killDest;
    wbEn = v.wbEn;          wbDest = v.wbDest;
    #1;
    checkOutput({v.name, " hazard"}, {31'd0, hazard}, {31'd0, v.expHazard});
    checkOutput({v.name, " sb_err"}, {31'd0, sbErr}, {31'd0, v.expSbErr});
    if (v.expHazard) expStall++;
  endtask

  initial begin
    //                name                 s1 s2 ts iv iw id kv kd we wd haz err
    vecs.push_back(mk("idle src1=2",        2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("issue r2",           0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("src1=2 wb r2",       2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0));
    vecs.push_back(mk("src1=2 retired",     2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("issue r5 a",         0, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("issue r5 b",         0, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("wb r5 first",        0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0));
    vecs.push_back(mk("src2=5 two_src",     0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("src2=5 one_src",     0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("wb r5 second",       0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0));
    vecs.push_back(mk("src2=5 drained",     0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("issue r7",           0, 0, 0, 1, 1, 7, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("issue+wb r7",        0, 0, 0, 1, 1, 7, 0, 0, 1, 7, 0, 0));
    vecs.push_back(mk("src1=7 net zero",    7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("wb r7",              0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0));
    vecs.push_back(mk("src1=7 drained",     7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("issue r3 a",         0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("issue r3 b",         0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("issue r3 c",         0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("r3 full stall",      0, 1, 1, 1, 1, 3, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("r3 full no-wb",      0, 1, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("wb r3 1of3",         0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0));
    vecs.push_back(mk("wb r3 2of3",         3, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0));
    vecs.push_back(mk("wb r3 3of3",         3, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0));
    vecs.push_back(mk("src1=3 drained",     3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("pc issue/kill/wb",  15,15, 1, 1, 1,15, 1,15, 1,15, 0, 0));
    vecs.push_back(mk("pc never busy",     15,15, 1, 0, 1,15, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("issue r6 a",         0, 0, 0, 1, 1, 6, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("issue r6 b",         0, 0, 0, 1, 1, 6, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("kill+wb r6",         6, 0, 0, 0, 0, 0, 1, 6, 1, 6, 1, 0));
    vecs.push_back(mk("src1=6 drained",     6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("issue r4",           0, 0, 0, 1, 1, 4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("kill r4",            4, 0, 0, 0, 0, 0, 1, 4, 0, 0, 1, 0));
    vecs.push_back(mk("src1=4 killed",      4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("wb r4 underflow",    0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0));
    vecs.push_back(mk("sb_err set",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("sb_err sticky",      4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("issue r8",           0, 0, 0, 1, 1, 8, 0, 0, 0, 0, 0, 1));

    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset hazard", {31'd0, hazard}, 32'd0);
    checkOutput("reset sb_err", {31'd0, sbErr}, 32'd0);
    checkOutput("reset stall_cycles", stallCycles, 32'd0);
    rstN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Asynchronous reset between edges while r8 is in flight.
    @(negedge clock);
    src1 = 4'd8; issValid = 1'b0; issWbEn = 1'b0; wbEn = 1'b0; killValid = 1'b0;
    #1;
    checkOutput("r8 busy before reset", {31'd0, hazard}, 32'd1);
    #1 rstN = 1'b0;
    #1;
    checkOutput("async reset hazard", {31'd0, hazard}, 32'd0);
    checkOutput("async reset sb_err", {31'd0, sbErr}, 32'd0);
    checkOutput("async reset stall_cycles", stallCycles, 32'd0);
    expStall = 0;
    #1 rstN = 1'b1;
    applyStimulus(mk("src1=8 after reset", 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Hold a dependent instruction for ten stalled edges.
    applyStimulus(mk("issue r9", 0, 0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 9; i++) begin
      applyStimulus(mk("hold src1=9", 9, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0));
    end
    applyStimulus(mk("hold src1=9 wb r9", 9, 0, 0, 1, 1, 1, 0, 0, 1, 9, 1, 0));
    applyStimulus(mk("src1=9 drained", 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

`ifdef HAZARD_SB_STALL_CNT_EN
    checkOutput("stall_cycles after hold", stallCycles, 32'(expStall));
`else
    checkOutput("stall_cycles tied off", stallCycles, 32'd0);
`endif

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

- Tracks every register write in flight between the decode stage and write-back.
- Drives the decode stage's `Hazard` stall input.
- The decode stage supplies its source addresses (`Hazard_src1`, `Hazard_src2`, `Two_src`) and its issued destination.
- The write-back stage supplies `WB_Dest`/`WB_WB_EN` to retire entries.
- A per-register pending counter replaces fixed stage-by-stage address compares, so pipeline depth and multi-cycle memory stalls need no change here.

## Interface
Parameters:
- ADDRESS_LEN_REG_FILE, 4: register address width.
- SIZE_REG_FILE, 15: number of tracked registers (R0..R14); addresses ≥ SIZE_REG_FILE are never tracked.
- MAX_INFLIGHT, 3: maximum outstanding writes per register; counter width CW = clog2(MAX_INFLIGHT+1).

Ports:
- clk, in, 1: the only clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-low reset.
- src1, in, ADDRESS_LEN_REG_FILE: Rn address of the instruction in decode; always checked.
- src2, in, ADDRESS_LEN_REG_FILE: Rm/Rd address of the instruction in decode.
- two_src, in, 1: src2 is checked only when 1.
- issue_valid, in, 1: the decode instruction advances into ID/EX this edge.
- issue_wb_en, in, 1: the issuing instruction writes a register.
- issue_dest, in, ADDRESS_LEN_REG_FILE: its destination.
- kill_valid, in, 1: the instruction currently in ID/EX is squashed by a taken branch.
- kill_dest, in, ADDRESS_LEN_REG_FILE: the squashed instruction's destination; meaningful only with kill_valid, and the caller asserts kill_valid only if that instruction had WB_EN.
- wb_wb_en, in, 1: write-back commits this edge.
- wb_dest, in, ADDRESS_LEN_REG_FILE: committed register.
- hazard, out, 1: stall decode; combinational.
- sb_err, out, 1: sticky underflow/illegal-event flag.
- stall_cycles, out, 32: stall performance counter (see Configuration).

## Operation
- State: cnt[r], CW bits, r = 0..SIZE_REG_FILE-1.
- Reset values: all cnt = 0, sb_err = 0, stall_cycles = 0, so hazard = 0.
- busy(a) = (a < SIZE_REG_FILE) && cnt[a] != 0.
- full(a) = (a < SIZE_REG_FILE) && cnt[a] == MAX_INFLIGHT.
- hazard = busy(src1) | (two_src & busy(src2)) | (issue_wb_en & full(issue_dest)).
  - The `issue_wb_en & full(issue_dest)` term is the overflow stall.
- Effective issue: inc = issue_valid & issue_wb_en & ~hazard & (issue_dest < SIZE_REG_FILE).
  - The block self-gates, so an issue_valid raised during hazard is ignored.
- dec_wb = wb_wb_en & (wb_dest < SIZE_REG_FILE).
- dec_k = kill_valid & (kill_dest < SIZE_REG_FILE).
- Per register, next cnt[r] = cnt[r] + inc_r − dec_wb_r − dec_k_r, all applied in the same edge.
  - Events that net to zero leave cnt unchanged, e.g. issue and retire of the same register.
- Underflow (requested decrement > cnt[r]): cnt[r] saturates at 0 and sb_err sets.
  - sb_err clears only on reset.
- Address 15 (PC) and any out-of-range address: never counted, never busy, never full.

## Timing
- hazard is purely combinational from registered cnt and the current decode inputs; zero-cycle latency.
- A same-edge write-back does not mask hazard. The register file value is consumed the cycle after cnt reaches 0.
- Minimum stall for a dependent instruction immediately behind its producer equals the issue→WB distance in cycles.
- rst low mid-operation clears all counts immediately (asynchronous) and deasserts hazard.
  - The pipeline is reset by the same signal, so no in-flight state survives.

## Configuration
- Macro: HAZARD_SB_STALL_CNT_EN.
- Defined: stall_cycles increments by 1 on every clk edge where hazard = 1 and rst is high; wraps modulo 2^32.
- Undefined: counter logic is not compiled and stall_cycles is tied to 32'd0. The port list is unchanged.

## Structure
- Shared package arm_pkg holds:
  - REG_ADDR_W = 4
  - NUM_GPR = 15
  - PC_ADDR = 4'd15
  - the typedef reg_addr_t
- One sub-module, sb_counter: a CW-bit saturating counter with one increment input, two decrement inputs, a max input and an underflow output.
  - Instantiated SIZE_REG_FILE times in a generate loop.
- Top level holds the address decoders, the hazard OR-tree, sb_err and the optional stall counter.

## Test plan
- Reset, then src1=2, two_src=0 → hazard=0. Issue dest=2 → next cycle src1=2 gives hazard=1. wb_dest=2 → following cycle hazard=0.
- Issue dest=5 twice, retire once → src2=5, two_src=1 gives hazard=1. With two_src=0 and src1=0 → hazard=0. Second retire → cnt[5]=0.
- Same edge: issue dest=7 and WB dest=7 with cnt[7]=1 → cnt[7] stays 1, hazard remains 1 for src1=7.
- Three issues to R3 (MAX_INFLIGHT=3), then issue_wb_en=1, issue_dest=3 with unrelated sources → hazard=1 and cnt[3] stays 3.
- Issue dest=4, then kill_valid=1, kill_dest=4 → cnt[4]=0, hazard cleared. WB to 4 with cnt=0 → sb_err=1 and stays 1 until rst low.
- Issue dest=15 and WB dest=15 → no count change, no sb_err. With HAZARD_SB_STALL_CNT_EN, holding hazard 10 cycles → stall_cycles=10. Without the macro → stall_cycles=0.
